uart_pingpong_engine: RTL and testbench
=======================================

Name: uart_pingpong_engine

Overview:
- Parametrised successor of the hand-written UART ping-pong test logic.
- Drives one UartTx and consumes one UartRx of the same design.
- Exchanges an incrementing token with a peer engine.
- Adds: role, width, step and round-count parameters; reply timeout; bounded retransmission; duplicate detection; status counters.
- Sits between the UART pair and the top-level test/bring-up logic.

Parameters:
- ROLE, 0, 0 = initiator (sends SEED first), 1 = responder.
- DATA_W, 8, token width; must equal the UART data width.
- SEED, 8'h61, first token sent by the initiator.
- STEP, 1, increment applied to each reply, modulo 2^DATA_W.
- NUM_ROUNDS, 16, number of correct exchanges before DONE; 0 = run forever.
- TIMEOUT_CYC, 200000, initiator wait-for-reply limit in CLK cycles; must be at least 2.
- MAX_RETRY, 3, retransmissions allowed per token before FAIL.

Ports:
- CLK  in  1  single clock; all logic is synchronous to it.
- RST  in  1  one clock; reset is synchronous and active-high.
- en  in  1  level; while low the FSM holds in or returns to IDLE at the next edge; counters are kept.
- tx_data  out  DATA_W  token to UartTx; stable while tx_we is high.
- tx_we  out  1  one-cycle write strobe to UartTx.
- tx_ready  in  1  UartTx can accept a byte.
- rx_data  in  DATA_W  received token; valid only when rx_en is high.
- rx_en  in  1  one-cycle receive strobe from UartRx.
- last_tx  out  DATA_W  most recently transmitted token.
- round_cnt  out  16  correct exchanges completed.
- err_cnt  out  8  mismatches plus timeouts; saturates at 255.
- done  out  1  sticky; NUM_ROUNDS reached.
- fail  out  1  sticky; retry budget exhausted.
- overrun  out  1  sticky; rx_en arrived outside WAIT_RX.

Behaviour:
- Reset values: all outputs 0, state IDLE, retry_cnt 0, timer 0, seen_first 0. RST mid-operation aborts and clears everything on that edge.
- States: IDLE, SEND, WAIT_RX, CHECK, DONE, FAIL.
- IDLE:
  - Initiator with en=1: load tx_data=SEED, go to SEND.
  - Responder with en=1: go to WAIT_RX.
- SEND:
  - tx_we=1 only in a cycle with tx_ready=1. last_tx<=tx_data in that same cycle.
  - Next state WAIT_RX; timer cleared. No other state asserts tx_we.
- WAIT_RX:
  - rx_en=1: capture rx_data, go to CHECK.
  - Initiator only: timer counts each cycle. At TIMEOUT_CYC-1 it is a timeout: err_cnt+1, then retry handling.
  - rx_en and timeout in the same cycle: rx_en wins, no timeout.
- CHECK: expected value is last_tx+STEP, truncated to DATA_W (wrap, e.g. 8'hFF+1=8'h00). One cycle, then:
  - Initiator, match: round_cnt+1, retry_cnt<=0. If round_cnt+1==NUM_ROUNDS go to DONE, else tx_data<=rx_data+STEP, go to SEND.
  - Initiator, mismatch: err_cnt+1, then retry handling.
  - Responder, first message (seen_first=0): must equal SEED.
  - Responder, later messages: must equal last_tx+STEP.
  - Responder, match: round_cnt+1, seen_first<=1, tx_data<=rx_data+STEP, go to SEND. After that send, if round_cnt==NUM_ROUNDS go to DONE.
  - Responder, duplicate (rx equals previous accepted token, seen_first=1): resend last_tx, no error.
  - Responder, other mismatch: err_cnt+1, stay in WAIT_RX.
- Retry handling (initiator): if retry_cnt==MAX_RETRY go to FAIL; else retry_cnt+1, tx_data<=last_tx, go to SEND.
- Turnaround: rx_en at cycle t gives tx_we no earlier than t+2, and exactly t+2 when tx_ready=1.
- DONE and FAIL are terminal until RST. They drop to IDLE if en falls, with done and fail kept sticky.
- rx_en in any state other than WAIT_RX: data dropped, overrun<=1.

Decomposition:
- Package uart_pp_pkg holds:
  - the state encoding (3-bit localparams IDLE..FAIL);
  - ROLE_INITIATOR=0 and ROLE_RESPONDER=1;
  - the err_cnt saturation limit.
- One sub-module, pp_timeout_timer (params TIMEOUT_CYC; ports CLK, RST, clr, run, expired), which computes its own counter width.

Test Plan:
- Two engines (ROLE 0/1) cross-wired through UartTx/UartRx, NUM_ROUNDS=4. Required:
  - tokens 61, 62, 63, 64, 65, 66, 67, 68 seen in order;
  - both round_cnt=4, both done=1, err_cnt=0.
- Wrap case: SEED=8'hFE, STEP=1, NUM_ROUNDS=2. Required: tokens FE, FF, 00, 01; both done=1.
- Initiator alone, no reply, TIMEOUT_CYC=50, MAX_RETRY=2. Required: three tx_we pulses of 61 spaced about 50 cycles apart, err_cnt=3, fail=1.
- Responder driven by the bench: rx 61, then 61 again. Required: two replies of 62, err_cnt=0. Then rx 70: err_cnt=1 and no tx_we.
- Hold tx_ready=0 for 20 cycles while in SEND. Required: no tx_we during those cycles; a single strobe in the first ready cycle with tx_data stable.
- Extra rx_en pulse while in SEND: overrun=1 and the token is ignored. Then RST mid-exchange: all outputs are 0 on the next edge, and the initiator resends 61.

Source files
------------

// File: rtl/uart_pp_pkg.sv
// Shared types and constants for the UART ping-pong engine.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pp_pkg;

    // State encoding.
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SEND    = 3'd1;
    localparam logic [2:0] WAIT_RX = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] FAIL    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = IDLE,
        ST_SEND    = SEND,
        ST_WAIT_RX = WAIT_RX,
        ST_CHECK   = CHECK,
        ST_DONE    = DONE,
        ST_FAIL    = FAIL
    } pp_state_t;

    localparam int ROLE_INITIATOR = 0;
    localparam int ROLE_RESPONDER = 1;

    // The error counter sticks at this value instead of wrapping.
    localparam logic [7:0] ERR_SAT = 8'd255;

    function automatic logic [7:0] err_inc(input logic [7:0] v);
        return (v == ERR_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_pingpong_engine_if.sv
// Byte-wide link between the ping-pong engine and its UartTx/UartRx pair.
// Latency: none (wires only).
// Backpressure: tx_ready from the UART gates tx_we; rx_en cannot be stalled.
interface uart_pingpong_engine_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_we;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_en;

    // Engine side.
    modport master (
        output tx_data, tx_we,
        input  tx_ready, rx_data, rx_en
    );

    // UART side.
    modport slave (
        input  tx_data, tx_we,
        output tx_ready, rx_data, rx_en
    );
endinterface

// File: rtl/pp_timeout_timer.sv
// Reply-wait timer: counts run cycles since clr and flags the last allowed cycle.
// Latency: expired is combinational from the count; count updates each edge.
// Backpressure: none; the count holds at its limit instead of wrapping.
module pp_timeout_timer #(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int            CW    = (TIMEOUT_CYC <= 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    // Cycle counter: cleared on each send, advances while waiting, parks at LIMIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = run && (cnt_q == LIMIT);
endmodule

// File: rtl/uart_pingpong_engine.sv
// Token ping-pong engine: exchanges an incrementing token with a peer over a UART pair.
// Latency: reply tx_we two cycles after rx_en when tx_ready is high.
// Backpressure: waits in SEND while tx_ready is low; rx_en outside WAIT_RX is dropped and flagged.
module uart_pingpong_engine
    import uart_pp_pkg::*;
#(
    parameter int                ROLE        = ROLE_INITIATOR,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] SEED        = 8'h61,
    parameter int                STEP        = 1,
    parameter int                NUM_ROUNDS  = 16,
    parameter int                TIMEOUT_CYC = 200000,
    parameter int                MAX_RETRY   = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    uart_pingpong_engine_if.master bus,
    output logic [DATA_W-1:0]     last_tx,
    output logic [15:0]           round_cnt,
    output logic [7:0]            err_cnt,
    output logic                  done,
    output logic                  fail,
    output logic                  overrun
);
    localparam bit                IS_INIT   = (ROLE != ROLE_RESPONDER);
    localparam logic [DATA_W-1:0] STEP_W    = DATA_W'(STEP);
    localparam logic [15:0]       ROUNDS    = 16'(NUM_ROUNDS);
    localparam int                RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);

    pp_state_t         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] last_tx_q, last_tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] last_rx_q, last_rx_d;
    logic [DATA_W-1:0] exp_tok;
    logic [15:0]       round_q, round_d;
    logic [7:0]        err_q, err_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              seen_first_q, seen_first_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic              overrun_q, overrun_d;
    logic              tx_we;
    logic              timer_clr, timer_run, timer_expired;
    logic              retry_req;

    pp_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (timer_clr),
        .run     (timer_run),
        .expired (timer_expired)
    );

    // Next-state and strobe logic; every register keeps its value unless a state updates it.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        last_tx_d    = last_tx_q;
        rx_d         = rx_q;
        last_rx_d    = last_rx_q;
        round_d      = round_q;
        err_d        = err_q;
        retry_d      = retry_q;
        seen_first_d = seen_first_q;
        done_d       = done_q;
        fail_d       = fail_q;
        overrun_d    = overrun_q;
        tx_we        = 1'b0;
        timer_clr    = 1'b0;
        timer_run    = 1'b0;
        retry_req    = 1'b0;
        // A responder's very first token must be SEED; afterwards the peer adds STEP to our last.
        exp_tok      = (!IS_INIT && !seen_first_q) ? SEED : last_tx_q + STEP_W;

        if (bus.rx_en && (state_q != ST_WAIT_RX)) begin
            overrun_d = 1'b1;
        end

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IS_INIT) begin
                        tx_data_d = SEED;
                        state_d   = ST_SEND;
                    end else begin
                        state_d   = ST_WAIT_RX;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        tx_we     = 1'b1;
                        last_tx_d = tx_data_q;
                        timer_clr = 1'b1;
                        if (!IS_INIT && (ROUNDS != 16'd0) && (round_q == ROUNDS)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT_RX;
                        end
                    end
                end
                ST_WAIT_RX: begin
                    // A reply in the expiry cycle still counts as a reply.
                    if (bus.rx_en) begin
                        rx_d    = bus.rx_data;
                        state_d = ST_CHECK;
                    end else if (IS_INIT) begin
                        timer_run = 1'b1;
                        if (timer_expired) begin
                            err_d     = err_inc(err_q);
                            retry_req = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (IS_INIT) begin
                        if (rx_q == exp_tok) begin
                            round_d = round_q + 16'd1;
                            retry_d = '0;
                            if ((ROUNDS != 16'd0) && (round_q + 16'd1 == ROUNDS)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                tx_data_d = rx_q + STEP_W;
                                state_d   = ST_SEND;
                            end
                        end else begin
                            err_d     = err_inc(err_q);
                            retry_req = 1'b1;
                        end
                    end else begin
                        if (rx_q == exp_tok) begin
                            round_d      = round_q + 16'd1;
                            seen_first_d = 1'b1;
                            last_rx_d    = rx_q;
                            tx_data_d    = rx_q + STEP_W;
                            state_d      = ST_SEND;
                        end else if (seen_first_q && (rx_q == last_rx_q)) begin
                            // Peer missed our reply and repeated itself: answer again, not an error.
                            tx_data_d = last_tx_q;
                            state_d   = ST_SEND;
                        end else begin
                            err_d   = err_inc(err_q);
                            state_d = ST_WAIT_RX;
                        end
                    end
                end
                ST_DONE, ST_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Shared by timeout and mismatch: resend the last token until the budget runs out.
            if (retry_req) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    retry_d   = retry_q + RW'(1);
                    tx_data_d = last_tx_q;
                    state_d   = ST_SEND;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= '0;
            last_tx_q    <= '0;
            rx_q         <= '0;
            last_rx_q    <= '0;
            round_q      <= '0;
            err_q        <= '0;
            retry_q      <= '0;
            seen_first_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            last_tx_q    <= last_tx_d;
            rx_q         <= rx_d;
            last_rx_q    <= last_rx_d;
            round_q      <= round_d;
            err_q        <= err_d;
            retry_q      <= retry_d;
            seen_first_q <= seen_first_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_we   = tx_we;
    assign last_tx     = last_tx_q;
    assign round_cnt   = round_q;
    assign err_cnt     = err_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_uart_pingpong_engine.sv
// Bench for uart_pingpong_engine: cross-wired engine pairs, a lone initiator and a bench-driven responder.
// Latency: expected tokens are queued per channel and popped by a monitor on each tx_we.
// Backpressure: tx_ready is held low in one phase to stall the lone initiator in SEND.
module tb_uart_pingpong_engine;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_p, en_p, rst_s, en_s, rst_r, en_r;

    // Instance index: 0 pair init, 1 pair resp, 2 wrap init, 3 wrap resp, 4 solo init, 5 bench-driven resp.
    logic [5:0][7:0]  last_w;
    logic [5:0][15:0] round_w;
    logic [5:0][7:0]  err_w;
    logic [5:0]       done_w, fail_w, ovr_w;

    uart_pingpong_engine_if #(.DATA_W(8)) if_pa ();
    uart_pingpong_engine_if #(.DATA_W(8)) if_pb ();
    uart_pingpong_engine_if #(.DATA_W(8)) if_wa ();
    uart_pingpong_engine_if #(.DATA_W(8)) if_wb ();
    uart_pingpong_engine_if #(.DATA_W(8)) if_s ();
    uart_pingpong_engine_if #(.DATA_W(8)) if_r ();

    uart_pingpong_engine #(.ROLE(0), .DATA_W(8), .SEED(8'h61), .STEP(1), .NUM_ROUNDS(4),
        .TIMEOUT_CYC(200000), .MAX_RETRY(3)) u_pa (
        .CLK(CLK), .RST(rst_p), .en(en_p), .bus(if_pa), .last_tx(last_w[0]), .round_cnt(round_w[0]),
        .err_cnt(err_w[0]), .done(done_w[0]), .fail(fail_w[0]), .overrun(ovr_w[0]));
    uart_pingpong_engine #(.ROLE(1), .DATA_W(8), .SEED(8'h61), .STEP(1), .NUM_ROUNDS(4),
        .TIMEOUT_CYC(200000), .MAX_RETRY(3)) u_pb (
        .CLK(CLK), .RST(rst_p), .en(en_p), .bus(if_pb), .last_tx(last_w[1]), .round_cnt(round_w[1]),
        .err_cnt(err_w[1]), .done(done_w[1]), .fail(fail_w[1]), .overrun(ovr_w[1]));
    uart_pingpong_engine #(.ROLE(0), .DATA_W(8), .SEED(8'hFE), .STEP(1), .NUM_ROUNDS(2),
        .TIMEOUT_CYC(200000), .MAX_RETRY(3)) u_wa (
        .CLK(CLK), .RST(rst_p), .en(en_p), .bus(if_wa), .last_tx(last_w[2]), .round_cnt(round_w[2]),
        .err_cnt(err_w[2]), .done(done_w[2]), .fail(fail_w[2]), .overrun(ovr_w[2]));
    uart_pingpong_engine #(.ROLE(1), .DATA_W(8), .SEED(8'hFE), .STEP(1), .NUM_ROUNDS(2),
        .TIMEOUT_CYC(200000), .MAX_RETRY(3)) u_wb (
        .CLK(CLK), .RST(rst_p), .en(en_p), .bus(if_wb), .last_tx(last_w[3]), .round_cnt(round_w[3]),
        .err_cnt(err_w[3]), .done(done_w[3]), .fail(fail_w[3]), .overrun(ovr_w[3]));
    uart_pingpong_engine #(.ROLE(0), .DATA_W(8), .SEED(8'h61), .STEP(1), .NUM_ROUNDS(16),
        .TIMEOUT_CYC(50), .MAX_RETRY(2)) u_s (
        .CLK(CLK), .RST(rst_s), .en(en_s), .bus(if_s), .last_tx(last_w[4]), .round_cnt(round_w[4]),
        .err_cnt(err_w[4]), .done(done_w[4]), .fail(fail_w[4]), .overrun(ovr_w[4]));
    uart_pingpong_engine #(.ROLE(1), .DATA_W(8), .SEED(8'h61), .STEP(1), .NUM_ROUNDS(16),
        .TIMEOUT_CYC(200000), .MAX_RETRY(3)) u_r (
        .CLK(CLK), .RST(rst_r), .en(en_r), .bus(if_r), .last_tx(last_w[5]), .round_cnt(round_w[5]),
        .err_cnt(err_w[5]), .done(done_w[5]), .fail(fail_w[5]), .overrun(ovr_w[5]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tx_cnt [4];
    int s_times [$];
    int r_last_cyc = 0;
    int rx_cyc = 0;

    // Expected tokens per channel: 0 pair, 1 wrap pair, 2 solo initiator, 3 bench-driven responder.
    logic [7:0] exp_q [4][$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic string ch_name(input int ch);
        case (ch)
            0:       return "pair";
            1:       return "wrap";
            2:       return "solo";
            default: return "resp";
        endcase
    endfunction

    task automatic sb_pop(input int ch, input logic [7:0] act);
        logic [7:0] e;
        total++;
        if (exp_q[ch].size() == 0) begin
            bad++;
            $display("FAIL sb_%s: unexpected tx_we with token %02h, expected no transmit", ch_name(ch), act);
        end else begin
            e = exp_q[ch].pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL sb_%s: token %02h, expected %02h", ch_name(ch), act, e);
            end
        end
    endtask

    // Monitor: every transmit strobe is checked against its channel's expectation queue.
    always @(negedge CLK) begin
        if (if_pa.tx_we) begin sb_pop(0, if_pa.tx_data); tx_cnt[0]++; end
        if (if_pb.tx_we) begin sb_pop(0, if_pb.tx_data); tx_cnt[0]++; end
        if (if_wa.tx_we) begin sb_pop(1, if_wa.tx_data); tx_cnt[1]++; end
        if (if_wb.tx_we) begin sb_pop(1, if_wb.tx_data); tx_cnt[1]++; end
        if (if_s.tx_we)  begin sb_pop(2, if_s.tx_data);  tx_cnt[2]++; s_times.push_back(cyc); end
        if (if_r.tx_we)  begin sb_pop(3, if_r.tx_data);  tx_cnt[3]++; r_last_cyc = cyc; end
    end

    // Link model for the two pairs: each transmit reappears one cycle later as a one-cycle rx_en at the peer.
    logic       ab_v = 1'b0, ba_v = 1'b0, wab_v = 1'b0, wba_v = 1'b0;
    logic [7:0] ab_d = 8'h00, ba_d = 8'h00, wab_d = 8'h00, wba_d = 8'h00;
    initial begin
        if_pa.rx_en = 1'b0; if_pa.rx_data = 8'h00; if_pb.rx_en = 1'b0; if_pb.rx_data = 8'h00;
        if_wa.rx_en = 1'b0; if_wa.rx_data = 8'h00; if_wb.rx_en = 1'b0; if_wb.rx_data = 8'h00;
        forever begin
            @(negedge CLK);
            if_pb.rx_en = ab_v;  if_pb.rx_data = ab_d;
            if_pa.rx_en = ba_v;  if_pa.rx_data = ba_d;
            if_wb.rx_en = wab_v; if_wb.rx_data = wab_d;
            if_wa.rx_en = wba_v; if_wa.rx_data = wba_d;
            ab_v  = if_pa.tx_we; ab_d  = if_pa.tx_data;
            ba_v  = if_pb.tx_we; ba_d  = if_pb.tx_data;
            wab_v = if_wa.tx_we; wab_d = if_wa.tx_data;
            wba_v = if_wb.tx_we; wba_d = if_wb.tx_data;
        end
    end

    task automatic resp_rx(input logic [7:0] d);
        if_r.rx_en = 1'b1;
        if_r.rx_data = d;
        rx_cyc = cyc;
        tick(1);
        if_r.rx_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_p = 1'b1; en_p = 1'b0; rst_s = 1'b1; en_s = 1'b0; rst_r = 1'b1; en_r = 1'b0;
        if_pa.tx_ready = 1'b1; if_pb.tx_ready = 1'b1; if_wa.tx_ready = 1'b1; if_wb.tx_ready = 1'b1;
        if_s.tx_ready = 1'b1; if_s.rx_en = 1'b0; if_s.rx_data = 8'h00;
        if_r.tx_ready = 1'b1; if_r.rx_en = 1'b0; if_r.rx_data = 8'h00;
        tick(3);

        // Reset values.
        chk("rst_tx_we",    if_pa.tx_we,   0);
        chk("rst_tx_data",  if_pa.tx_data, 0);
        chk("rst_last_tx",  last_w[0],     0);
        chk("rst_round",    round_w[0],    0);
        chk("rst_err",      err_w[0],      0);
        chk("rst_flags",    {done_w[0], fail_w[0], ovr_w[0]}, 0);

        // Cross-wired pairs: 61..68 and the wrapping FE, FF, 00, 01.
        exp_q[0].push_back(8'h61); exp_q[0].push_back(8'h62); exp_q[0].push_back(8'h63); exp_q[0].push_back(8'h64);
        exp_q[0].push_back(8'h65); exp_q[0].push_back(8'h66); exp_q[0].push_back(8'h67); exp_q[0].push_back(8'h68);
        exp_q[1].push_back(8'hFE); exp_q[1].push_back(8'hFF); exp_q[1].push_back(8'h00); exp_q[1].push_back(8'h01);
        rst_p = 1'b0; en_p = 1'b1;
        for (int i = 0; i < 400 && !(&done_w[3:0]); i++) tick(1);
        chk("pairs_done_in_budget", done_w[3:0], 4'hF);
        tick(10);
        chk("pair_init_round",  round_w[0], 4);
        chk("pair_resp_round",  round_w[1], 4);
        chk("pair_err",         {err_w[0], err_w[1]}, 0);
        chk("pair_fail",        {fail_w[0], fail_w[1]}, 0);
        chk("pair_tokens_left", exp_q[0].size(), 0);
        chk("pair_tx_count",    tx_cnt[0], 8);
        chk("wrap_round",       {round_w[2], round_w[3]}, {16'd2, 16'd2});
        chk("wrap_tokens_left", exp_q[1].size(), 0);
        chk("wrap_tx_count",    tx_cnt[1], 4);

        // Lone initiator with no peer: three sends of 61, 50 waiting cycles plus one send cycle apart.
        exp_q[2].push_back(8'h61); exp_q[2].push_back(8'h61); exp_q[2].push_back(8'h61);
        rst_s = 1'b0; en_s = 1'b1;
        for (int i = 0; i < 400 && !fail_w[4]; i++) tick(1);
        chk("solo_fail", fail_w[4], 1);
        tick(60);
        chk("solo_err",      err_w[4], 3);
        chk("solo_tx_count", tx_cnt[2], 3);
        chk("solo_done",     done_w[4], 0);
        if (s_times.size() == 3) begin
            chk("solo_gap1", s_times[1] - s_times[0], 51);
            chk("solo_gap2", s_times[2] - s_times[1], 51);
        end

        // Stall in SEND for 20 cycles with a stray rx_en in the middle.
        if_s.tx_ready = 1'b0;
        rst_s = 1'b1;
        tick(1);
        rst_s = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin if_s.rx_en = 1'b1; if_s.rx_data = 8'h62; end
            if (i == 11) if_s.rx_en = 1'b0;
            tick(1);
        end
        chk("stall_no_we",     tx_cnt[2], 3);
        chk("stall_overrun",   ovr_w[4], 1);
        chk("stall_tx_data",   if_s.tx_data, 8'h61);
        chk("stall_err",       err_w[4], 0);
        exp_q[2].push_back(8'h61);
        if_s.tx_ready = 1'b1;
        tick(2);
        chk("stall_single_we", tx_cnt[2], 4);
        chk("stall_last_tx",   last_w[4], 8'h61);

        // Reset while waiting for a reply clears everything on that edge.
        rst_s = 1'b1;
        tick(1);
        chk("midrst_tx_we",   if_s.tx_we, 0);
        chk("midrst_tx_data", if_s.tx_data, 0);
        chk("midrst_last_tx", last_w[4], 0);
        chk("midrst_counts",  {round_w[4], err_w[4]}, 0);
        chk("midrst_flags",   {done_w[4], fail_w[4], ovr_w[4]}, 0);
        exp_q[2].push_back(8'h61);
        rst_s = 1'b0;
        for (int i = 0; i < 10 && exp_q[2].size() != 0; i++) tick(1);
        chk("midrst_resend", tx_cnt[2], 5);
        en_s = 1'b0;

        // Bench-driven responder: 61, duplicate 61, bad 70, then valid 63.
        rst_r = 1'b0; en_r = 1'b1;
        tick(3);
        exp_q[3].push_back(8'h62);
        resp_rx(8'h61);
        tick(5);
        chk("resp_first_reply", tx_cnt[3], 1);
        chk("resp_turnaround",  r_last_cyc - rx_cyc, 2);
        chk("resp_round1",      round_w[5], 1);
        exp_q[3].push_back(8'h62);
        resp_rx(8'h61);
        tick(5);
        chk("resp_dup_reply",   tx_cnt[3], 2);
        chk("resp_dup_err",     err_w[5], 0);
        chk("resp_dup_round",   round_w[5], 1);
        resp_rx(8'h70);
        tick(10);
        chk("resp_bad_err",     err_w[5], 1);
        chk("resp_bad_no_we",   tx_cnt[3], 2);
        exp_q[3].push_back(8'h64);
        resp_rx(8'h63);
        tick(5);
        chk("resp_next_round",  round_w[5], 2);
        chk("resp_next_reply",  tx_cnt[3], 3);
        chk("resp_overrun",     ovr_w[5], 0);

        chk("solo_tokens_left", exp_q[2].size(), 0);
        chk("resp_tokens_left", exp_q[3].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
